// File: rtl/adder_chk_pkg.sv
// Shared definitions for the TMR adder checking path: capture-stage state
// encoding and the two-rail error decode.
package adder_chk_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  // Complementary rails (01/10) mean the voted result is trustworthy.
  function automatic logic rails_good(input logic xe0, input logic xe1);
    return xe0 ^ xe1;
  endfunction

endpackage

// File: rtl/result_fifo2.sv
// Two-entry first-in first-out buffer; head is the oldest entry and holds
// steady until popped.
module result_fifo2 #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign push_ok = push & (count != 2'd2);
  assign pop_ok  = pop & (count != 2'd0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adder_result_capture.sv
// Capture stage for the TMR 3-bit adder: buffers results with their error
// flag and tracks error history, locking out input after a run of bad results.
module adder_result_capture #(
  parameter int WIDTH        = 3,
  parameter int ERR_CNT_W    = 8,
  parameter int FAULT_THRESH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic                 in_xc,
  input  logic                 in_xe0,
  input  logic                 in_xe1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       out_sum,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           state,
  output logic                 fault,
  input  logic                 clr_fault
);
  import adder_chk_pkg::*;

  localparam int          EW     = WIDTH + 2;
  localparam logic [4:0]  THRESH = 5'(FAULT_THRESH);

  state_t          st;
  logic [3:0]      consec;
  logic [4:0]      consec_next;
  logic            hit_thresh;
  logic            flagged;
  logic            accept;
  logic            pop;
  logic [1:0]      fifo_count;
  logic [EW-1:0]   head;

  // Handshake: a transfer happens on any edge where valid & ready are both
  // high; valid never waits on ready, and in_ready is a function of
  // registered state only (FIFO occupancy and FSM state).
  assign flagged   = ~rails_good(in_xe0, in_xe1);
  assign in_ready  = (fifo_count != 2'd2) & (st != ST_FAULT);
  assign accept    = in_valid & in_ready;
  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & out_ready;

  assign consec_next = {1'b0, consec} + 5'd1;
  assign hit_thresh  = (consec_next >= THRESH);

  assign out_sum = head[WIDTH:0];
  assign out_err = head[WIDTH+1];
  assign state   = st;
  assign fault   = (st == ST_FAULT);

  result_fifo2 #(.W(EW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .din   ({flagged, in_xc, in_x}),
    .head  (head),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_NORMAL;
      consec    <= 4'd0;
      err_count <= '0;
    end else begin
      if (accept && flagged && (err_count != {ERR_CNT_W{1'b1}})) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
      case (st)
        ST_NORMAL, ST_SUSPECT: begin
          if (accept) begin
            if (flagged) begin
              consec <= consec_next[4] ? consec : consec_next[3:0];
              st     <= hit_thresh ? ST_FAULT : ST_SUSPECT;
            end else begin
              consec <= 4'd0;
              st     <= ST_NORMAL;
            end
          end
        end
        // Only software can leave FAULT; the error total survives the clear.
        ST_FAULT: begin
          if (clr_fault) begin
            consec <= 4'd0;
            st     <= ST_NORMAL;
          end
        end
        default: begin
          consec <= 4'd0;
          st     <= ST_NORMAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_result_capture.sv
// Bench for adder_result_capture: directed vector table, queue-based model
// under random traffic, mid-burst reset, and counter saturation on a
// second narrow instance.
module tb_adder_result_capture;

  localparam int EW = 5;

  logic       clk;
  logic       rst_n;

  logic       a_in_valid, a_in_ready, a_in_xc, a_in_xe0, a_in_xe1;
  logic [2:0] a_in_x;
  logic       a_out_valid, a_out_ready, a_out_err, a_fault, a_clr_fault;
  logic [3:0] a_out_sum;
  logic [7:0] a_err_count;
  logic [1:0] a_state;

  logic       b_in_valid, b_in_ready, b_in_xc, b_in_xe0, b_in_xe1;
  logic [2:0] b_in_x;
  logic       b_out_valid, b_out_ready, b_out_err, b_fault, b_clr_fault;
  logic [3:0] b_out_sum;
  logic [1:0] b_err_count;
  logic [1:0] b_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queued words plus error bookkeeping.
  logic [EW-1:0] exp_q[$];
  int m_err;
  int m_consec;
  bit m_fault;

  typedef struct {
    logic       v;
    logic [2:0] x;
    logic       xc, e0, e1, r, c;
    logic       ov;
    logic [3:0] sum;
    logic       err;
    logic       rdy;
    logic [1:0] st;
    logic [7:0] ec;
  } vec_t;

  vec_t vq[$];

  adder_result_capture #(.WIDTH(3), .ERR_CNT_W(8), .FAULT_THRESH(3)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_x(a_in_x), .in_xc(a_in_xc),
    .in_xe0(a_in_xe0), .in_xe1(a_in_xe1),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum), .out_err(a_out_err),
    .err_count(a_err_count), .state(a_state), .fault(a_fault), .clr_fault(a_clr_fault)
  );

  adder_result_capture #(.WIDTH(3), .ERR_CNT_W(2), .FAULT_THRESH(15)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_x(b_in_x), .in_xc(b_in_xc),
    .in_xe0(b_in_xe0), .in_xe1(b_in_xe1),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum), .out_err(b_out_err),
    .err_count(b_err_count), .state(b_state), .fault(b_fault), .clr_fault(b_clr_fault)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic v, input logic [2:0] x, input logic xc, input logic e0,
                         input logic e1, input logic r, input logic c, input logic ov,
                         input logic [3:0] sum, input logic err, input logic rdy,
                         input logic [1:0] st, input logic [7:0] ec);
    vec_t t;
    t.v = v; t.x = x; t.xc = xc; t.e0 = e0; t.e1 = e1; t.r = r; t.c = c;
    t.ov = ov; t.sum = sum; t.err = err; t.rdy = rdy; t.st = st; t.ec = ec;
    vq.push_back(t);
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_err    = 0;
    m_consec = 0;
    m_fault  = 0;
  endfunction

  // Driver for instance A: apply inputs, compare against the model, advance
  // the model and the clock by one cycle.
  task automatic cycle(input logic v, input logic [2:0] x, input logic xc, input logic e0,
                       input logic e1, input logic r, input logic c);
    bit acc;
    bit flag;
    a_in_valid  = v;
    a_in_x      = x;
    a_in_xc     = xc;
    a_in_xe0    = e0;
    a_in_xe1    = e1;
    a_out_ready = r;
    a_clr_fault = c;
    chk("m.in_ready", a_in_ready, (exp_q.size() < 2 && !m_fault));
    chk("m.out_valid", a_out_valid, (exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("m.out_sum", a_out_sum, exp_q[0][3:0]);
      chk("m.out_err", a_out_err, exp_q[0][4]);
    end
    chk("m.err_count", a_err_count, m_err);
    chk("m.state", a_state, m_fault ? 2 : (m_consec > 0 ? 1 : 0));
    chk("m.fault", a_fault, m_fault);
    acc  = v && exp_q.size() < 2 && !m_fault;
    flag = (e0 == e1);
    if (exp_q.size() != 0 && r) void'(exp_q.pop_front());
    if (m_fault && c) begin
      m_fault  = 0;
      m_consec = 0;
    end else if (acc) begin
      exp_q.push_back({flag, xc, x});
      if (flag) begin
        if (m_err < 255) m_err++;
        m_consec++;
        if (m_consec >= 3) m_fault = 1;
      end else begin
        m_consec = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_flag;
    bit flag;
    logic [3:0] prev;
    rst_n = 1'b0;
    a_in_valid = 0; a_in_x = 0; a_in_xc = 0; a_in_xe0 = 0; a_in_xe1 = 0;
    a_out_ready = 0; a_clr_fault = 0;
    b_in_valid = 0; b_in_x = 0; b_in_xc = 0; b_in_xe0 = 0; b_in_xe1 = 0;
    b_out_ready = 1; b_clr_fault = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values
    chk("rst.in_ready", a_in_ready, 1);
    chk("rst.out_valid", a_out_valid, 0);
    chk("rst.out_sum", a_out_sum, 0);
    chk("rst.out_err", a_out_err, 0);
    chk("rst.err_count", a_err_count, 0);
    chk("rst.state", a_state, 0);
    chk("rst.fault", a_fault, 0);

    // Directed table: inputs, then expected outputs after the edge.
    //      v  x  xc e0 e1 r  c   ov sum      err rdy st ec
    add_vec(1, 5, 1, 0, 1, 1, 0,  1, 4'b1101, 0,  1,  0, 0);
    add_vec(0, 0, 0, 0, 1, 1, 0,  0, 4'b0000, 0,  1,  0, 0);
    add_vec(1, 1, 0, 0, 1, 0, 0,  1, 4'b0001, 0,  1,  0, 0);
    add_vec(1, 2, 0, 1, 0, 0, 0,  1, 4'b0001, 0,  0,  0, 0);
    add_vec(1, 3, 1, 0, 1, 0, 0,  1, 4'b0001, 0,  0,  0, 0);
    add_vec(1, 3, 1, 0, 1, 1, 0,  1, 4'b0010, 0,  1,  0, 0);
    add_vec(1, 3, 1, 0, 1, 0, 0,  1, 4'b0010, 0,  0,  0, 0);
    add_vec(0, 0, 0, 0, 1, 1, 0,  1, 4'b1011, 0,  1,  0, 0);
    add_vec(0, 0, 0, 0, 1, 1, 0,  0, 4'b0000, 0,  1,  0, 0);
    add_vec(1, 4, 0, 1, 1, 1, 0,  1, 4'b0100, 1,  1,  1, 1);
    add_vec(1, 6, 1, 0, 0, 1, 0,  1, 4'b1110, 1,  1,  1, 2);
    add_vec(1, 7, 0, 1, 1, 0, 0,  1, 4'b1110, 1,  0,  2, 3);
    add_vec(1, 0, 0, 0, 1, 1, 0,  1, 4'b0111, 1,  0,  2, 3);
    add_vec(0, 0, 0, 0, 1, 1, 0,  0, 4'b0000, 0,  0,  2, 3);
    add_vec(0, 0, 0, 0, 1, 1, 1,  0, 4'b0000, 0,  1,  0, 3);
    add_vec(1, 1, 0, 1, 1, 1, 0,  1, 4'b0001, 1,  1,  1, 4);
    add_vec(1, 2, 0, 1, 0, 1, 0,  1, 4'b0010, 0,  1,  0, 4);
    add_vec(1, 3, 0, 0, 0, 1, 0,  1, 4'b0011, 1,  1,  1, 5);
    add_vec(0, 0, 0, 0, 1, 1, 0,  0, 4'b0000, 0,  1,  1, 5);
    add_vec(0, 0, 0, 0, 1, 1, 1,  0, 4'b0000, 0,  1,  1, 5);

    for (int i = 0; i < vq.size(); i++) begin
      cycle(vq[i].v, vq[i].x, vq[i].xc, vq[i].e0, vq[i].e1, vq[i].r, vq[i].c);
      chk($sformatf("vec%0d.out_valid", i), a_out_valid, vq[i].ov);
      if (vq[i].ov) begin
        chk($sformatf("vec%0d.out_sum", i), a_out_sum, vq[i].sum);
        chk($sformatf("vec%0d.out_err", i), a_out_err, vq[i].err);
      end
      chk($sformatf("vec%0d.in_ready", i), a_in_ready, vq[i].rdy);
      chk($sformatf("vec%0d.state", i), a_state, vq[i].st);
      chk($sformatf("vec%0d.fault", i), a_fault, (vq[i].st == 2'd2));
      chk($sformatf("vec%0d.err_count", i), a_err_count, vq[i].ec);
    end

    // Ten good words back to back, one per cycle, in order.
    for (int i = 0; i < 10; i++) begin
      cycle(1, 3'(i), 1'(i >> 3), 1'(i & 1), 1'(~i & 1), 1, 0);
      prev = {1'(i >> 3), 3'(i)};
      chk($sformatf("stream%0d.out_sum", i), a_out_sum, prev);
      chk($sformatf("stream%0d.out_valid", i), a_out_valid, 1);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
    end

    // Mid-burst reset with two flagged words queued.
    repeat (3) cycle(0, 0, 0, 0, 1, 1, 1);
    cycle(1, 5, 1, 1, 1, 0, 0);
    cycle(1, 2, 0, 0, 0, 0, 0);
    chk("pre_rst.out_valid", a_out_valid, 1);
    chk("pre_rst.in_ready", a_in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst.out_valid", a_out_valid, 0);
    chk("mid_rst.err_count", a_err_count, 0);
    chk("mid_rst.state", a_state, 0);
    chk("mid_rst.in_ready", a_in_ready, 1);
    chk("mid_rst.fault", a_fault, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    a_in_valid = 0;
    cycle(0, 0, 0, 0, 1, 1, 0);

    // Saturation on the narrow instance: alternate flagged and good words.
    n_flag = 0;
    for (int k = 0; k < 8; k++) begin
      flag = (k % 2 == 0);
      chk($sformatf("sat%0d.in_ready", k), b_in_ready, 1);
      b_in_valid = 1;
      b_in_x     = 3'(k);
      b_in_xc    = 0;
      b_in_xe0   = 1;
      b_in_xe1   = flag;
      @(posedge clk);
      #1;
      if (flag) n_flag++;
      chk($sformatf("sat%0d.err_count", k), b_err_count, (n_flag > 3) ? 3 : n_flag);
      chk($sformatf("sat%0d.state", k), b_state, flag ? 1 : 0);
      chk($sformatf("sat%0d.fault", k), b_fault, 0);
    end
    b_in_valid = 0;
    repeat (2) @(posedge clk);
    #1 chk("sat.hold", b_err_count, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
